// File: rtl/hazard_forward_unit.sv
// Pipeline control carrier: ID/EX, EX/MEM and MEM/WB control registers, load-use
// stall / IF-ID flush generation, and EX-stage operand forwarding selects.
module hazard_forward_unit (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] PC_ctrl_i,
  input  logic [4:0] EX_ctrl_i,
  input  logic [1:0] MEM_ctrl_i,
  input  logic [1:0] WB_ctrl_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic [4:0] rd_i,
  output logic       pc_write_o,
  output logic       ifid_write_o,
  output logic       ifid_flush_o,
  output logic [4:0] ex_ctrl_o,
  output logic [4:0] ex_rs_o,
  output logic [4:0] ex_rt_o,
  output logic [4:0] ex_wreg_o,
  output logic [1:0] mem_ctrl_o,
  output logic [4:0] mem_wreg_o,
  output logic [1:0] wb_ctrl_o,
  output logic [4:0] wb_wreg_o,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o
);

  // ID/EX
  logic [4:0] idex_ex_q,  idex_ex_d;
  logic [4:0] idex_rs_q,  idex_rs_d;
  logic [4:0] idex_rt_q,  idex_rt_d;
  logic [4:0] idex_rd_q,  idex_rd_d;
  logic       idex_mcs_q, idex_mcs_d;
  logic       idex_mwe_q, idex_mwe_d;
  logic       idex_wbm_q, idex_wbm_d;
  logic       idex_rwe_q, idex_rwe_d;
  // EX/MEM
  logic       exmem_mcs_q, exmem_mwe_q, exmem_wbm_q, exmem_rwe_q;
  logic [4:0] exmem_wreg_q;
  // MEM/WB
  logic       memwb_wbm_q, memwb_rwe_q;
  logic [4:0] memwb_wreg_q;

  logic       stall;
  logic       pc_ctrl_unused;

  // Only the redirect bit matters here; jump vs. branch is resolved upstream.
  assign pc_ctrl_unused = PC_ctrl_i[0];

  assign stall = idex_mcs_q & ~idex_mwe_q & idex_rwe_q & (idex_rt_q != '0) &
                 ((idex_rt_q == rs_i) | (idex_rt_q == rt_i));

  assign pc_write_o   = ~stall;
  assign ifid_write_o = ~stall;
  assign ifid_flush_o = ~stall & PC_ctrl_i[1];

  // Decoder don't-care fields are masked so they can never enable a memory
  // access or register write on their own.
  always_comb begin
    idex_ex_d  = '0;
    idex_rs_d  = '0;
    idex_rt_d  = '0;
    idex_rd_d  = '0;
    idex_mcs_d = 1'b0;
    idex_mwe_d = 1'b0;
    idex_wbm_d = 1'b0;
    idex_rwe_d = 1'b0;
    if (!stall) begin
      idex_ex_d  = EX_ctrl_i;
      idex_rs_d  = rs_i;
      idex_rt_d  = rt_i;
      idex_rd_d  = rd_i;
      idex_mcs_d = MEM_ctrl_i[1] & (MEM_ctrl_i[0] | WB_ctrl_i[0]);
      idex_mwe_d = MEM_ctrl_i[0];
      idex_wbm_d = WB_ctrl_i[1] & WB_ctrl_i[0];
      idex_rwe_d = WB_ctrl_i[0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idex_ex_q    <= '0;
      idex_rs_q    <= '0;
      idex_rt_q    <= '0;
      idex_rd_q    <= '0;
      idex_mcs_q   <= 1'b0;
      idex_mwe_q   <= 1'b0;
      idex_wbm_q   <= 1'b0;
      idex_rwe_q   <= 1'b0;
      exmem_mcs_q  <= 1'b0;
      exmem_mwe_q  <= 1'b0;
      exmem_wbm_q  <= 1'b0;
      exmem_rwe_q  <= 1'b0;
      exmem_wreg_q <= '0;
      memwb_wbm_q  <= 1'b0;
      memwb_rwe_q  <= 1'b0;
      memwb_wreg_q <= '0;
    end else begin
      idex_ex_q    <= idex_ex_d;
      idex_rs_q    <= idex_rs_d;
      idex_rt_q    <= idex_rt_d;
      idex_rd_q    <= idex_rd_d;
      idex_mcs_q   <= idex_mcs_d;
      idex_mwe_q   <= idex_mwe_d;
      idex_wbm_q   <= idex_wbm_d;
      idex_rwe_q   <= idex_rwe_d;
      exmem_mcs_q  <= idex_mcs_q;
      exmem_mwe_q  <= idex_mwe_q;
      exmem_wbm_q  <= idex_wbm_q;
      exmem_rwe_q  <= idex_rwe_q;
      exmem_wreg_q <= ex_wreg_o;
      memwb_wbm_q  <= exmem_wbm_q;
      memwb_rwe_q  <= exmem_rwe_q;
      memwb_wreg_q <= exmem_wreg_q;
    end
  end

  assign ex_ctrl_o  = idex_ex_q;
  assign ex_rs_o    = idex_rs_q;
  assign ex_rt_o    = idex_rt_q;
  assign ex_wreg_o  = idex_ex_q[0] ? idex_rd_q : idex_rt_q;
  assign mem_ctrl_o = {exmem_mcs_q, exmem_mwe_q};
  assign mem_wreg_o = exmem_wreg_q;
  assign wb_ctrl_o  = {memwb_wbm_q, memwb_rwe_q};
  assign wb_wreg_o  = memwb_wreg_q;

  // EX/MEM result is newer than MEM/WB, so it wins when both match.
  always_comb begin
    fwd_a_o = 2'b00;
    fwd_b_o = 2'b00;
    if (exmem_rwe_q && exmem_wreg_q != '0 && exmem_wreg_q == idex_rs_q)
      fwd_a_o = 2'b10;
    else if (memwb_rwe_q && memwb_wreg_q != '0 && memwb_wreg_q == idex_rs_q)
      fwd_a_o = 2'b01;
    if (exmem_rwe_q && exmem_wreg_q != '0 && exmem_wreg_q == idex_rt_q)
      fwd_b_o = 2'b10;
    else if (memwb_rwe_q && memwb_wreg_q != '0 && memwb_wreg_q == idex_rt_q)
      fwd_b_o = 2'b01;
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: directed test-plan sequences plus
// random instruction streams checked against an instruction-history model.
module tb_hazard_forward_unit;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [1:0] PC_ctrl_i;
  logic [4:0] EX_ctrl_i;
  logic [1:0] MEM_ctrl_i;
  logic [1:0] WB_ctrl_i;
  logic [4:0] rs_i, rt_i, rd_i;
  logic       pc_write_o, ifid_write_o, ifid_flush_o;
  logic [4:0] ex_ctrl_o, ex_rs_o, ex_rt_o, ex_wreg_o, mem_wreg_o, wb_wreg_o;
  logic [1:0] mem_ctrl_o, wb_ctrl_o, fwd_a_o, fwd_b_o;

  hazard_forward_unit dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .PC_ctrl_i(PC_ctrl_i), .EX_ctrl_i(EX_ctrl_i), .MEM_ctrl_i(MEM_ctrl_i),
    .WB_ctrl_i(WB_ctrl_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
    .ex_ctrl_o(ex_ctrl_o), .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_wreg_o(ex_wreg_o),
    .mem_ctrl_o(mem_ctrl_o), .mem_wreg_o(mem_wreg_o),
    .wb_ctrl_o(wb_ctrl_o), .wb_wreg_o(wb_wreg_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0] pc;
    logic [4:0] ex;
    logic [1:0] mem;
    logic [1:0] wb;
    logic [4:0] rs, rt, rd;
  } ins_t;

  // What an instruction means once it has entered EX (bubble = all zero).
  typedef struct packed {
    logic [4:0] ex;
    logic [4:0] rs, rt, rd;
    logic       is_load_or_store, is_store, result_from_alu, writes_reg;
  } rec_t;

  typedef struct packed {
    logic       pcw, ifw, fl;
    logic [4:0] exc, exrs, exrt, exwr;
    logic [1:0] memc;
    logic [4:0] memw;
    logic [1:0] wbc;
    logic [4:0] wbw;
    logic [1:0] fa, fb;
  } exp_t;

  rec_t hist[$];   // instructions that entered EX, oldest first
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  logic last_stall = 1'b0;
  ins_t last_ins;

  function automatic rec_t older(int unsigned k);
    if (hist.size() > k) return hist[hist.size() - 1 - k];
    return '0;
  endfunction

  function automatic logic [4:0] dest(rec_t r);
    return r.ex[0] ? r.rd : r.rt;
  endfunction

  function automatic logic [1:0] fwd(logic [4:0] src);
    rec_t m = older(1);
    rec_t w = older(2);
    if (src == 0) return 2'b00;
    if (m.writes_reg && dest(m) == src) return 2'b10;
    if (w.writes_reg && dest(w) == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic rec_t enter(ins_t i);
    rec_t r;
    r.ex = i.ex; r.rs = i.rs; r.rt = i.rt; r.rd = i.rd;
    r.writes_reg       = i.wb[0];
    r.is_store         = i.mem[0];
    r.is_load_or_store = i.mem[1] && (i.mem[0] || i.wb[0]);
    r.result_from_alu  = i.wb[1] && i.wb[0];
    return r;
  endfunction

  function automatic ins_t mk(logic [1:0] pc, logic [4:0] ex, logic [1:0] mem,
                              logic [1:0] wb, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    ins_t i;
    i.pc = pc; i.ex = ex; i.mem = mem; i.wb = wb; i.rs = rs; i.rt = rt; i.rd = rd;
    return i;
  endfunction

  function automatic ins_t add_i(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    return mk(2'b00, 5'b01001, 2'b00, 2'b11, rs, rt, rd);
  endfunction
  function automatic ins_t lw_i(logic [4:0] rs, logic [4:0] rt);
    return mk(2'b00, 5'b00010, 2'b10, 2'b01, rs, rt, 5'd9);
  endfunction
  function automatic ins_t sw_i(logic [4:0] rs, logic [4:0] rt);
    return mk(2'b00, 5'b00010, 2'b11, 2'b10, rs, rt, 5'd9);
  endfunction
  function automatic ins_t addi_i(logic [4:0] rs, logic [4:0] rt);
    return mk(2'b00, 5'b00010, 2'b00, 2'b11, rs, rt, 5'd6);
  endfunction
  // Branch/jump leave MEM/WB fields as don't-cares; drive them with junk.
  function automatic ins_t beq_i(logic [4:0] rs, logic [4:0] rt, logic taken);
    return mk({taken, taken}, 5'b00100, 2'b10, 2'b10, rs, rt, 5'd8);
  endfunction
  function automatic ins_t j_i();
    return mk(2'b10, 5'b00000, 2'b10, 2'b10, 5'd3, 5'd4, 5'd5);
  endfunction

  // One cycle: apply inputs just after the edge, predict this cycle's outputs,
  // then record what the coming edge loads into EX.
  task automatic step(input logic rst_n, input ins_t i);
    exp_t e;
    rec_t x;
    logic st;
    @(posedge clk_i);
    #1;
    rst_n_i = rst_n;
    {PC_ctrl_i, EX_ctrl_i, MEM_ctrl_i, WB_ctrl_i, rs_i, rt_i, rd_i} = i;
    if (!rst_n) hist.delete();
    x = older(0);
    st = x.is_load_or_store && !x.is_store && x.writes_reg && x.rt != 0 &&
         (x.rt == i.rs || x.rt == i.rt);
    e.pcw = !st; e.ifw = !st; e.fl = !st && i.pc[1];
    e.exc = x.ex; e.exrs = x.rs; e.exrt = x.rt; e.exwr = dest(x);
    e.memc = {older(1).is_load_or_store, older(1).is_store};
    e.memw = dest(older(1));
    e.wbc  = {older(2).result_from_alu, older(2).writes_reg};
    e.wbw  = dest(older(2));
    e.fa = fwd(x.rs); e.fb = fwd(x.rt);
    sb.push_back(e);
    if (rst_n) begin
      hist.push_back(st ? rec_t'('0) : enter(i));
      if (hist.size() > 3) void'(hist.pop_front());
    end
    last_stall = st && rst_n;
    last_ins = i;
  endtask

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc_write",   {4'b0, pc_write_o},   {4'b0, e.pcw});
        chk("ifid_write", {4'b0, ifid_write_o}, {4'b0, e.ifw});
        chk("ifid_flush", {4'b0, ifid_flush_o}, {4'b0, e.fl});
        chk("ex_ctrl",  ex_ctrl_o,  e.exc);
        chk("ex_rs",    ex_rs_o,    e.exrs);
        chk("ex_rt",    ex_rt_o,    e.exrt);
        chk("ex_wreg",  ex_wreg_o,  e.exwr);
        chk("mem_ctrl", {3'b0, mem_ctrl_o}, {3'b0, e.memc});
        chk("mem_wreg", mem_wreg_o, e.memw);
        chk("wb_ctrl",  {3'b0, wb_ctrl_o},  {3'b0, e.wbc});
        chk("wb_wreg",  wb_wreg_o,  e.wbw);
        chk("fwd_a",    {3'b0, fwd_a_o}, {3'b0, e.fa});
        chk("fwd_b",    {3'b0, fwd_b_o}, {3'b0, e.fb});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : driver
    ins_t nop, r;
    nop = '0;
    rst_n_i = 1'b0;
    {PC_ctrl_i, EX_ctrl_i, MEM_ctrl_i, WB_ctrl_i, rs_i, rt_i, rd_i} = '1;
    // Reset with nonzero inputs, then ADD rd=3 through to WB
    step(1'b0, add_i(5'd1, 5'd2, 5'd3));
    step(1'b0, lw_i(5'd4, 5'd5));
    step(1'b1, add_i(5'd1, 5'd2, 5'd3));
    repeat (3) step(1'b1, nop);
    // Load-use: LW rt=5, ADD rs=5 (stalls once, then re-presented)
    step(1'b1, lw_i(5'd1, 5'd5));
    step(1'b1, add_i(5'd5, 5'd2, 5'd6));
    step(1'b1, add_i(5'd5, 5'd2, 5'd6));
    repeat (3) step(1'b1, nop);
    // Forward priority: two writers of r7, then a reader of r7 on both ports
    step(1'b1, add_i(5'd1, 5'd2, 5'd7));
    step(1'b1, add_i(5'd3, 5'd4, 5'd7));
    step(1'b1, add_i(5'd7, 5'd7, 5'd8));
    step(1'b1, nop);
    step(1'b1, add_i(5'd1, 5'd2, 5'd7));
    step(1'b1, nop);
    step(1'b1, add_i(5'd7, 5'd7, 5'd8));
    repeat (3) step(1'b1, nop);
    // Redirects
    step(1'b1, j_i());
    step(1'b1, beq_i(5'd1, 5'd2, 1'b1));
    step(1'b1, beq_i(5'd1, 5'd2, 1'b0));
    repeat (3) step(1'b1, nop);
    // Stall beats redirect
    step(1'b1, lw_i(5'd1, 5'd4));
    step(1'b1, beq_i(5'd4, 5'd2, 1'b1));
    step(1'b1, beq_i(5'd4, 5'd2, 1'b1));
    repeat (3) step(1'b1, nop);
    // Register 0 never stalls nor forwards
    step(1'b1, lw_i(5'd1, 5'd0));
    step(1'b1, add_i(5'd0, 5'd0, 5'd2));
    step(1'b1, addi_i(5'd1, 5'd0));
    step(1'b1, add_i(5'd0, 5'd0, 5'd2));
    step(1'b1, add_i(5'd0, 5'd3, 5'd2));
    // Reset while a stall is pending
    step(1'b1, lw_i(5'd1, 5'd6));
    step(1'b0, add_i(5'd6, 5'd6, 5'd2));
    step(1'b1, add_i(5'd6, 5'd6, 5'd2));
    repeat (3) step(1'b1, nop);
    // Random streams over a small register set to provoke hazards
    for (int unsigned n = 0; n < 600; n++) begin
      if (last_stall) r = last_ins;
      else begin
        case ($urandom_range(0, 5))
          0: r = add_i(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
          1: r = lw_i(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
          2: r = sw_i(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
          3: r = addi_i(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
          4: r = beq_i(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
          default: r = j_i();
        endcase
        r.ex[4:2] = 3'($urandom);
        r.rd = 5'($urandom_range(0, 7));
      end
      step(($urandom_range(0, 59) != 0), r);
    end
    @(negedge clk_i);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
